// File: rtl/adbg_jtag_tap.sv
// IEEE 1149.1 TAP controller for the advanced debug unit: TAP FSM, IR, BYPASS and optional IDCODE DR.
// Latency: state strobes track the TAP state with no added delay; tdo_o is retimed on the falling edge of tck_i.
// Backpressure: none, the JTAG host owns the pace via tck_i. Define ADBG_TAP_IDCODE_EN to build the IDCODE DR.
module adbg_jtag_tap #(
    parameter int unsigned          IR_WIDTH     = 4,
    parameter logic [31:0]          IDCODE_VALUE = 32'h1000_5AA5,
    parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE = 4'h2,
    parameter logic [IR_WIDTH-1:0]  INSTR_DEBUG  = 4'h8,
    parameter logic [IR_WIDTH-1:0]  INSTR_BYPASS = 4'hF
) (
    input  logic tck_i,
    input  logic trstn_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic debug_tdo_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic test_logic_reset_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic debug_select_o,
    output logic tap_access_o
);

    typedef enum logic [3:0] {
        ST_TLR    = 4'h0,
        ST_RTI    = 4'h1,
        ST_SEL_DR = 4'h2,
        ST_CAP_DR = 4'h3,
        ST_SH_DR  = 4'h4,
        ST_EX1_DR = 4'h5,
        ST_PAU_DR = 4'h6,
        ST_EX2_DR = 4'h7,
        ST_UPD_DR = 4'h8,
        ST_SEL_IR = 4'h9,
        ST_CAP_IR = 4'hA,
        ST_SH_IR  = 4'hB,
        ST_EX1_IR = 4'hC,
        ST_PAU_IR = 4'hD,
        ST_EX2_IR = 4'hE,
        ST_UPD_IR = 4'hF
    } tap_state_t;

    // Fixed pattern captured into the IR shift register; the trailing 01 lets a host find the IR length.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

`ifdef ADBG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = INSTR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = INSTR_BYPASS;
`endif

    tap_state_t            r_state;
    tap_state_t            w_next;
    logic                  r_tlr;
    logic                  r_shift_dr;
    logic                  r_pause_dr;
    logic                  r_update_dr;
    logic                  r_capture_dr;
    logic [IR_WIDTH-1:0]   r_ir_sh;
    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   w_ir_next;
    logic                  r_debug_select;
    logic                  r_bypass;
    logic                  w_dr_tdo;
    logic                  r_tdo;
    logic                  r_tdo_oe;

    // Standard 1149.1 TMS transition table.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:    w_next = tms_i ? ST_TLR    : ST_RTI;
            ST_RTI:    w_next = tms_i ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: w_next = tms_i ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: w_next = tms_i ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  w_next = tms_i ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: w_next = tms_i ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: w_next = tms_i ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: w_next = tms_i ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: w_next = tms_i ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: w_next = tms_i ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: w_next = tms_i ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  w_next = tms_i ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: w_next = tms_i ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: w_next = tms_i ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: w_next = tms_i ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: w_next = tms_i ? ST_SEL_DR : ST_RTI;
            default:   w_next = ST_TLR;
        endcase
    end

    // State register plus strobes decoded from the next state, so each flop mirrors the state with no skew or glitch.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_state      <= ST_TLR;
            r_tlr        <= 1'b1;
            r_shift_dr   <= 1'b0;
            r_pause_dr   <= 1'b0;
            r_update_dr  <= 1'b0;
            r_capture_dr <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_tlr        <= (w_next == ST_TLR);
            r_shift_dr   <= (w_next == ST_SH_DR);
            r_pause_dr   <= (w_next == ST_PAU_DR);
            r_update_dr  <= (w_next == ST_UPD_DR);
            r_capture_dr <= (w_next == ST_CAP_DR);
        end
    end

    // Latched IR takes the shifted value when leaving Update-IR; entering Test-Logic-Reset wins and reloads the default.
    always_comb begin
        w_ir_next = r_ir;
        if (r_state == ST_UPD_IR) begin
            w_ir_next = r_ir_sh;
        end
        if (w_next == ST_TLR) begin
            w_ir_next = IR_RESET;
        end
    end

    // IR shift path and latched IR; debug_select is registered alongside so it never lags the IR.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_ir_sh        <= '0;
            r_ir           <= IR_RESET;
            r_debug_select <= (IR_RESET == INSTR_DEBUG);
        end else begin
            if (r_state == ST_CAP_IR) begin
                r_ir_sh <= IR_CAPTURE;
            end else if (r_state == ST_SH_IR) begin
                r_ir_sh <= {tdi_i, r_ir_sh[IR_WIDTH-1:1]};
            end
            r_ir           <= w_ir_next;
            r_debug_select <= (w_ir_next == INSTR_DEBUG);
        end
    end

    // Single-bit BYPASS register: cleared on capture, follows TDI while shifting.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_bypass <= 1'b0;
        end else if (r_state == ST_CAP_DR) begin
            r_bypass <= 1'b0;
        end else if (r_state == ST_SH_DR) begin
            r_bypass <= tdi_i;
        end
    end

`ifdef ADBG_TAP_IDCODE_EN
    logic [31:0] r_idcode;
    logic        w_sel_idcode;
    logic        w_unused_cfg;

    // BYPASS opcode is only reached as the catch-all decode here.
    assign w_unused_cfg = ^INSTR_BYPASS;
    assign w_sel_idcode = (r_ir == INSTR_IDCODE);

    // IDCODE chain: parallel load on capture, LSB-first shift with TDI entering at the MSB.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_idcode <= '0;
        end else if (r_state == ST_CAP_DR) begin
            r_idcode <= IDCODE_VALUE;
        end else if (r_state == ST_SH_DR) begin
            r_idcode <= {tdi_i, r_idcode[31:1]};
        end
    end

    // DR serial output selected by the latched IR; anything not DEBUG or IDCODE is BYPASS.
    always_comb begin
        w_dr_tdo = r_bypass;
        if (r_debug_select) begin
            w_dr_tdo = debug_tdo_i;
        end else if (w_sel_idcode) begin
            w_dr_tdo = r_idcode[0];
        end
    end
`else
    logic w_unused_cfg;

    // IDCODE parameters have no hardware in this build; IDCODE opcode falls through to BYPASS.
    assign w_unused_cfg = ^{IDCODE_VALUE, INSTR_IDCODE};

    // DR serial output selected by the latched IR; anything not DEBUG is BYPASS.
    always_comb begin
        w_dr_tdo = r_bypass;
        if (r_debug_select) begin
            w_dr_tdo = debug_tdo_i;
        end
    end
`endif

    // TDO and its enable retimed on the falling edge so the host samples stable data on the next rising edge.
    always_ff @(negedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else if (r_state == ST_SH_IR) begin
            r_tdo    <= r_ir_sh[0];
            r_tdo_oe <= 1'b1;
        end else if (r_state == ST_SH_DR) begin
            r_tdo    <= w_dr_tdo;
            r_tdo_oe <= 1'b1;
        end else begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end
    end

    assign tdo_o              = r_tdo;
    assign tdo_oe_o           = r_tdo_oe;
    assign test_logic_reset_o = r_tlr;
    assign shift_dr_o         = r_shift_dr;
    assign pause_dr_o         = r_pause_dr;
    assign update_dr_o        = r_update_dr;
    assign capture_dr_o       = r_capture_dr;
    assign debug_select_o     = r_debug_select;
    assign tap_access_o       = r_debug_select & ~r_tlr;

endmodule
